mac_worker: RTL and testbench
=============================

Name: mac_worker

Overview:
- Compute-side responder to the accelerator's top-level start/done sequencer.
- Decodes the sequencer's 3-bit `state` bus. On entry to the run state it:
  - streams LEN operand pairs from two synchronous-read buffers;
  - accumulates their signed products;
  - presents the result and returns a single-cycle `finish` pulse to the sequencer.
- Sits between the sequencer and the operand buffers; `finish` feeds the sequencer's `finish` input directly.

Parameters:
- DATA_W, 8, operand width (signed two's complement)
- ADDR_W, 6, buffer address width
- ACC_W, 2*DATA_W+ADDR_W, accumulator/result width (overflow-free for max length)
- RUN_STATE, 3'd2, `state` encoding on which the worker triggers; defined in shared package

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- state  in  3  sequencer state bus
- len  in  ADDR_W+1  number of operand pairs, sampled at trigger; range 0..2^ADDR_W
- rd_en  out  1  read strobe to both operand buffers
- rd_addr  out  ADDR_W  read address, shared by both buffers
- a_data  in  DATA_W  buffer A read data, valid one cycle after rd_en
- b_data  in  DATA_W  buffer B read data, valid one cycle after rd_en
- res_valid  out  1  result strobe, one cycle
- res_data  out  ACC_W  signed accumulated result, held until next trigger
- finish  out  1  one-cycle completion pulse to sequencer
- busy  out  1  high from FETCH through DONE

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - rd_en, rd_addr, res_valid, res_data, finish, busy, accumulator, counters and run_q all 0.
- Trigger = (state==RUN_STATE) && !run_q, where run_q is `state==RUN_STATE` registered. Only the rising edge of the run condition triggers; a held run state does not retrigger.
- FSM states:
  - IDLE -> FETCH on trigger with len!=0: latch len, clear accumulator.
  - IDLE -> DONE on trigger with len==0: accumulator cleared, so res_data=0.
  - FETCH: rd_en=1, rd_addr=0,1,…,len-1, one per cycle, len consecutive cycles; after issuing len-1 go to DRAIN.
  - DRAIN: one cycle, rd_en=0; final returned pair accumulated.
  - DONE: one cycle; res_valid=1, finish=1, res_data=accumulator -> WAIT_LOW.
  - WAIT_LOW: stay until state!=RUN_STATE, then IDLE. No second finish while run is held.
- Accumulate: one cycle after each rd_en, acc <= acc + sign-extended (a_data*b_data), signed multiply, full 2*DATA_W product, no saturation needed at default ACC_W.
- Latency: trigger detected in cycle T, then:
  - rd_en high in cycles T+1..T+len;
  - finish/res_valid in cycle T+len+2;
  - len==0 case: finish in T+1.
- Abort: state leaves RUN_STATE while in FETCH or DRAIN -> IDLE next edge.
  - rd_en drops, no finish, no res_valid.
  - res_data keeps its previous value; accumulator discarded.
- Simultaneous: trigger can only occur in IDLE. Triggers arriving in other states are ignored; run_q still tracks.
- len==2^ADDR_W: rd_addr wraps only after the last issue, never re-issues address 0.
- busy = state in {FETCH, DRAIN, DONE}.
- Reset mid-operation: immediate return to reset values; no finish.

Decomposition:
- Shared package accel_pkg holds:
  - sequencer state encodings (IDLE/RUN/… including RUN_STATE);
  - worker FSM encoding: IDLE, FETCH, DRAIN, DONE, WAIT_LOW;
  - default DATA_W/ADDR_W.
- One natural sub-module, mac_unit: registered signed multiply-accumulate with clear and enable (enable = rd_en delayed one cycle), instantiated once.

Test Plan:
- Reset held 20 ns, then release -> all outputs 0, FSM IDLE, no rd_en while state!=RUN_STATE.
- len=4, A={1,2,3,4}, B={5,6,7,8}, state->RUN_STATE -> rd_en 4 cycles addr 0..3; finish pulse at T+6, res_data=70, single pulse.
- Signed operands len=2, A={-128,127}, B={127,-128} -> res_data=-32512, finish once.
- len=0 -> no rd_en, finish and res_valid at T+1, res_data=0.
- len=8, state drops out of RUN_STATE after 3 fetch cycles -> rd_en deasserts next cycle, no finish, res_data keeps prior value; re-entering RUN_STATE restarts from addr 0.
- Run held 50 cycles after finish, then low, then high again with len=1, A={3}, B={-2} -> exactly one finish per entry; second res_data=-6.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator encodings: sequencer state bus, worker FSM states, default widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package accel_pkg;

  // Sequencer state bus encodings as seen by all workers
  localparam logic [2:0] SEQ_IDLE  = 3'd0;
  localparam logic [2:0] SEQ_LOAD  = 3'd1;
  localparam logic [2:0] RUN_STATE = 3'd2;
  localparam logic [2:0] SEQ_WAIT  = 3'd3;

  // Worker FSM encodings
  localparam logic [2:0] W_IDLE     = 3'd0;
  localparam logic [2:0] W_FETCH    = 3'd1;
  localparam logic [2:0] W_DRAIN    = 3'd2;
  localparam logic [2:0] W_DONE     = 3'd3;
  localparam logic [2:0] W_WAIT_LOW = 3'd4;

  // Default datapath geometry
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

endpackage

// File: rtl/mac_worker_if.sv
// Bundle between sequencer/operand buffers and the MAC worker.
// Latency: n/a (wires only).
// Backpressure: none; buffers answer every read one cycle later.
interface mac_worker_if
  import accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = 2*DATA_W + ADDR_W
);
  logic [2:0]        state;
  logic [ADDR_W:0]   len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              finish;
  logic              busy;

  // Worker side
  modport master (
    input  state, len, a_data, b_data,
    output rd_en, rd_addr, res_valid, res_data, finish, busy
  );

  // Sequencer / buffer side
  modport slave (
    output state, len, a_data, b_data,
    input  rd_en, rd_addr, res_valid, res_data, finish, busy
  );
endinterface

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear (clear wins over enable).
// Latency: product folded into the accumulator on the edge where en is high.
// Backpressure: none; accepts one operand pair per enabled cycle.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_d
);
  logic [ACC_W-1:0]          acc_q;
  logic signed [2*DATA_W-1:0] prod;

  // Next accumulator value; exposed so the caller can capture the final sum on the same edge
  always_comb begin
    prod  = $signed(a) * $signed(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/mac_worker.sv
// MAC worker: on a rising run condition streams len operand pairs, sums products, pulses finish.
// Latency: rd_en T+1..T+len, finish T+len+2 (T+1 when len==0), T = trigger cycle.
// Backpressure: none; leaving the run state mid-fetch aborts without finish.
module mac_worker
  import accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_worker_if.master  io
);
  logic [2:0]        fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ACC_W-1:0]  res_q, res_d;
  logic              run_q, run_d;
  logic              mac_en_q, mac_en_d;
  logic              trig;
  logic              clr;
  logic              rd_en;
  logic [ACC_W-1:0]  acc_d;

  // Run-condition edge detect and read strobe
  always_comb begin
    run_d    = (io.state == RUN_STATE);
    trig     = run_d && !run_q;
    rd_en    = (fsm_q == W_FETCH);
    mac_en_d = rd_en;
  end

  // Worker FSM, address counter, length latch and result capture
  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    len_d  = len_q;
    res_d  = res_q;
    clr    = 1'b0;
    case (fsm_q)
      W_IDLE: begin
        if (trig) begin
          clr    = 1'b1;
          len_d  = io.len;
          addr_d = '0;
          fsm_d  = (io.len != '0) ? W_FETCH : W_DONE;
        end
      end
      W_FETCH: begin
        if (!run_d) begin
          fsm_d  = W_IDLE;
          addr_d = '0;
        end else if ({1'b0, addr_q} == len_q - 1'b1) begin
          // Last address issued; park at 0 rather than wrapping into a re-issue
          fsm_d  = W_DRAIN;
          addr_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      W_DRAIN:    fsm_d = run_d ? W_DONE : W_IDLE;
      W_DONE:     fsm_d = W_WAIT_LOW;
      W_WAIT_LOW: if (!run_d) fsm_d = W_IDLE;
      default:    fsm_d = W_IDLE;
    endcase
    // Final product lands on the same edge we enter DONE, so capture the next value
    if (fsm_d == W_DONE) res_d = acc_d;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= W_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      res_q    <= '0;
      run_q    <= 1'b0;
      mac_en_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      res_q    <= res_d;
      run_q    <= run_d;
      mac_en_q <= mac_en_d;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (mac_en_q),
    .a     (io.a_data),
    .b     (io.b_data),
    .acc_d (acc_d)
  );

  // Output drive
  always_comb begin
    io.rd_en     = rd_en;
    io.rd_addr   = addr_q;
    io.res_valid = (fsm_q == W_DONE);
    io.finish    = (fsm_q == W_DONE);
    io.res_data  = res_q;
    io.busy      = (fsm_q == W_FETCH) || (fsm_q == W_DRAIN) || (fsm_q == W_DONE);
  end
endmodule

// File: tb/tb_mac_worker.sv
// Self-checking bench for mac_worker: directed cases plus randomized runs against a sum-of-products model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mac_worker;
  import accel_pkg::*;

  logic clk;
  logic rst_n;

  mac_worker_if io ();

  mac_worker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  logic signed [7:0] mem_a [64];
  logic signed [7:0] mem_b [64];
  int     n_chk;
  int     n_err;
  longint last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers: synchronous read, data one cycle after rd_en
  always @(posedge clk) begin
    if (io.rd_en) begin
      io.a_data <= mem_a[io.rd_addr];
      io.b_data <= mem_b[io.rd_addr];
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  // Full run: trigger, check every cycle through finish, hold run, then release
  task automatic do_run(input int n, input int hold);
    longint exp_sum;
    int     fin_k;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += longint'(mem_a[i]) * longint'(mem_b[i]);
    fin_k = (n == 0) ? 1 : n + 2;
    @(negedge clk);
    io.len   = 7'(n);
    io.state = RUN_STATE;
    for (int k = 1; k <= fin_k + 1; k++) begin
      @(posedge clk); #1;
      chk("rd_en", io.rd_en, longint'(k <= n));
      if (k <= n) chk("rd_addr", io.rd_addr, k - 1);
      chk("finish", io.finish, longint'(k == fin_k));
      chk("res_valid", io.res_valid, longint'(k == fin_k));
      chk("busy", io.busy, longint'(k <= fin_k));
      chk("res_data", $signed(io.res_data), (k >= fin_k) ? exp_sum : last_res);
    end
    last_res = exp_sum;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_finish", io.finish, 0);
      chk("hold_rd_en", io.rd_en, 0);
    end
    @(negedge clk);
    io.state = SEQ_IDLE;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", io.busy, 0);
  endtask

  // Start a run, leave the run state after nf fetch cycles, confirm a clean abort
  task automatic do_abort(input int n, input int nf);
    @(negedge clk);
    io.len   = 7'(n);
    io.state = RUN_STATE;
    for (int k = 1; k <= nf; k++) begin
      @(posedge clk); #1;
      chk("ab_rd_en", io.rd_en, 1);
      chk("ab_rd_addr", io.rd_addr, k - 1);
    end
    @(negedge clk);
    io.state = SEQ_IDLE;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("ab_rd_en_off", io.rd_en, 0);
      chk("ab_finish", io.finish, 0);
      chk("ab_res_valid", io.res_valid, 0);
      chk("ab_busy", io.busy, 0);
      chk("ab_res_data", $signed(io.res_data), last_res);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, io.rd_en, 0);
    chk({tag, "_rd_addr"}, io.rd_addr, 0);
    chk({tag, "_finish"}, io.finish, 0);
    chk({tag, "_res_valid"}, io.res_valid, 0);
    chk({tag, "_res_data"}, io.res_data, 0);
    chk({tag, "_busy"}, io.busy, 0);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    last_res = 0;
    rst_n    = 1'b0;
    io.state  = SEQ_IDLE;
    io.len    = '0;
    io.a_data = '0;
    io.b_data = '0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    #12;
    chk_zero("in_rst");
    #8;
    rst_n = 1'b1;
    io.state = SEQ_LOAD;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_zero("post_rst");
    end

    // len=4 basic: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    do_run(4, 3);
    chk("basic_70", last_res, 70);

    // Signed extremes
    mem_a[0] = -8'sd128; mem_b[0] = 8'sd127;
    mem_a[1] = 8'sd127;  mem_b[1] = -8'sd128;
    do_run(2, 1);
    chk("signed_sum", last_res, -32512);

    // Zero length
    do_run(0, 2);

    // Abort after 3 fetch cycles, then a clean rerun from address 0
    fill_rand();
    do_abort(8, 3);
    do_run(8, 0);

    // Long hold without retrigger, then a single-pair run
    do_run(3, 50);
    mem_a[0] = 8'sd3;
    mem_b[0] = -8'sd2;
    do_run(1, 2);
    chk("second_res", last_res, -6);

    // Randomized runs, including maximum length
    for (int r = 0; r < 12; r++) begin
      int n;
      n = (r == 0) ? 64 : int'($urandom_range(0, 64));
      fill_rand();
      if (n > 1 && $urandom_range(0, 3) == 0) do_abort(n, int'($urandom_range(1, n - 1)));
      else                                    do_run(n, int'($urandom_range(0, 5)));
    end
    do_run(64, 1);

    // Reset in the middle of a fetch
    fill_rand();
    @(negedge clk);
    io.len   = 7'd20;
    io.state = RUN_STATE;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", io.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    io.state = SEQ_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_zero("after_mid_rst");
    end
    do_run(5, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
